// File: rtl/seq_restoring_divider.sv
// ----------------------------------------------------------------------------
// seq_restoring_divider
//
// Sequential unsigned restoring divider. Divides a 2*WIDTH-bit dividend by a
// WIDTH-bit divisor, producing one quotient bit per clock after a one-cycle
// operand check. Divide-by-zero and quotient overflow are detected up front
// and reported without running the iteration.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request; sampled only while busy is low
//   dividend     2*WIDTH-bit numerator, captured on the accepted start
//   divisor      WIDTH-bit denominator, captured on the accepted start
//   busy         operation in progress (start ignored while high)
//   done         one-cycle pulse; quotient/remainder/flags valid
//   quotient     WIDTH-bit quotient, held until the next result
//   remainder    WIDTH-bit remainder, held until the next result
//   div_by_zero  set with done when the divisor was zero
//   overflow     set with done when the quotient would not fit in WIDTH bits
// ----------------------------------------------------------------------------
module seq_restoring_divider #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;

    logic [2*WIDTH-1:0]   dvd_r;
    logic [2*WIDTH-1:0]   dvd_s;
    logic [WIDTH-1:0]     dvs_r;
    logic [WIDTH-1:0]     dvs_s;
    // Partial remainder: always < divisor between iterations, so WIDTH bits suffice.
    logic [WIDTH-1:0]     rem_r;
    logic [WIDTH-1:0]     rem_s;
    // Low dividend bits shift out at the top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0]     q_r;
    logic [WIDTH-1:0]     q_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_s;

    logic                 busy_r;
    logic                 busy_s;
    logic                 done_r;
    logic                 done_s;
    logic [WIDTH-1:0]     quotient_r;
    logic [WIDTH-1:0]     quotient_s;
    logic [WIDTH-1:0]     remainder_r;
    logic [WIDTH-1:0]     remainder_s;
    logic                 dbz_r;
    logic                 dbz_s;
    logic                 ovf_r;
    logic                 ovf_s;

    // One iteration of the restoring step.
    logic [WIDTH:0]       trial_s;
    logic [WIDTH-1:0]     rem_step_s;
    logic [WIDTH-1:0]     q_step_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Restoring step: shift one dividend bit into the remainder, subtract if it fits.
    always_comb begin
        trial_s    = {rem_r, q_r[WIDTH-1]};
        rem_step_s = trial_s[WIDTH-1:0];
        q_step_s   = {q_r[WIDTH-2:0], 1'b0};
        if (trial_s >= {1'b0, dvs_r}) begin
            // Result is < divisor, so the modular low-bit difference is exact.
            rem_step_s = trial_s[WIDTH-1:0] - dvs_r;
            q_step_s   = {q_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_step_s = trial_s[WIDTH-1:0];
            q_step_s   = {q_r[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts on it.
    always_comb begin
        state_s     = state_r;
        dvd_s       = dvd_r;
        dvs_s       = dvs_r;
        rem_s       = rem_r;
        q_s         = q_r;
        cnt_s       = cnt_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        quotient_s  = quotient_r;
        remainder_s = remainder_r;
        dbz_s       = dbz_r;
        ovf_s       = ovf_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    dvd_s   = dividend;
                    dvs_s   = divisor;
                    dbz_s   = 1'b0;
                    ovf_s   = 1'b0;
                    busy_s  = 1'b1;
                    state_s = ST_CHECK;
                end else begin
                    busy_s  = 1'b0;
                end
            end

            ST_CHECK: begin
                if (dvs_r == {WIDTH{1'b0}}) begin
                    quotient_s  = {WIDTH{1'b1}};
                    remainder_s = dvd_r[WIDTH-1:0];
                    dbz_s       = 1'b1;
                    done_s      = 1'b1;
                    busy_s      = 1'b0;
                    state_s     = ST_IDLE;
                end else if (dvd_r[2*WIDTH-1:WIDTH] >= dvs_r) begin
                    // High half >= divisor means the quotient needs more than WIDTH bits.
                    quotient_s  = {WIDTH{1'b1}};
                    remainder_s = {WIDTH{1'b0}};
                    ovf_s       = 1'b1;
                    done_s      = 1'b1;
                    busy_s      = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    rem_s   = dvd_r[2*WIDTH-1:WIDTH];
                    q_s     = dvd_r[WIDTH-1:0];
                    cnt_s   = CNT_W'(WIDTH);
                    state_s = ST_RUN;
                end
            end

            ST_RUN: begin
                rem_s = rem_step_s;
                q_s   = q_step_s;
                cnt_s = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    quotient_s  = q_step_s;
                    remainder_s = rem_step_s;
                    done_s      = 1'b1;
                    busy_s      = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    state_s     = ST_RUN;
                end
            end

            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_r       <= {(2*WIDTH){1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            q_r         <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            dvd_r       <= dvd_s;
            dvs_r       <= dvs_s;
            rem_r       <= rem_s;
            q_r         <= q_s;
            cnt_r       <= cnt_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            quotient_r  <= quotient_s;
            remainder_r <= remainder_s;
            dbz_r       <= dbz_s;
            ovf_r       <= ovf_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;
    assign overflow    = ovf_r;

endmodule
